// File: rtl/wishbone_arbiter.sv
// ---------------------------------------------------------------------------
// wishbone_arbiter
//   Two-master, one-slave Wishbone arbiter sitting between an instruction-fetch
//   port, a data port and a single memory. Data normally wins a tie, but an
//   ifetch that has watched STARVE_LIMIT data grants go by wins the next tie.
//
//   Ports
//     clk, rst          : clock (rising edge) and asynchronous active-high reset
//     i_*               : ifetch-side slave port (12-bit line address, 128-bit data)
//     d_*               : data-side slave port (same shape as ifetch side)
//     m_*               : memory-side master port
//     grant             : 00 idle, 01 ifetch owns memory, 10 data owns memory
//
//   The address/data path is purely combinational from the granted side, so
//   the arbiter adds no latency beyond the one IDLE arbitration cycle.
// ---------------------------------------------------------------------------
module wishbone_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,

    input  logic [11:0]  i_ADR,
    input  logic [15:0]  i_SEL,
    input  logic         i_STB,
    input  logic         i_CYC,
    input  logic         i_WE,
    input  logic [127:0] i_DAT_M,
    output logic [127:0] i_DAT_S,
    output logic         i_ACK,

    input  logic [11:0]  d_ADR,
    input  logic [15:0]  d_SEL,
    input  logic         d_STB,
    input  logic         d_CYC,
    input  logic         d_WE,
    input  logic [127:0] d_DAT_M,
    output logic [127:0] d_DAT_S,
    output logic         d_ACK,

    output logic [11:0]  m_ADR,
    output logic [15:0]  m_SEL,
    output logic         m_STB,
    output logic         m_CYC,
    output logic         m_WE,
    output logic [127:0] m_DAT_M,
    input  logic [127:0] m_DAT_S,
    input  logic         m_ACK,

    output logic [1:0]   grant
);

    localparam int unsigned CW_RAW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    // Encoding doubles as the grant output value.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    logic i_req, d_req;

    assign i_req = i_CYC & i_STB;
    assign d_req = d_CYC & d_STB;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Next-state and starvation counter
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    if (starve_cnt_q == LIMIT_C) begin
                        state_d      = GNT_I;
                        starve_cnt_d = '0;
                    end else begin
                        // Data wins the tie; ifetch has now waited one more grant.
                        state_d      = GNT_D;
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (i_req) begin
                    state_d      = GNT_I;
                    starve_cnt_d = '0;
                end else if (d_req) begin
                    state_d      = GNT_D;
                end
            end
            // Transaction ends on memory ACK or when the owner abandons CYC.
            GNT_I: if (m_ACK || !i_CYC) state_d = IDLE;
            GNT_D: if (m_ACK || !d_CYC) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-side mux and ACK steering
    always_comb begin
        m_ADR   = '0;
        m_SEL   = '0;
        m_STB   = 1'b0;
        m_CYC   = 1'b0;
        m_WE    = 1'b0;
        m_DAT_M = '0;
        i_ACK   = 1'b0;
        d_ACK   = 1'b0;
        case (state_q)
            GNT_I: begin
                m_ADR   = i_ADR;
                m_SEL   = i_SEL;
                m_STB   = i_STB;
                m_CYC   = i_CYC;
                m_WE    = i_WE;
                m_DAT_M = i_DAT_M;
                i_ACK   = m_ACK;
            end
            GNT_D: begin
                m_ADR   = d_ADR;
                m_SEL   = d_SEL;
                m_STB   = d_STB;
                m_CYC   = d_CYC;
                m_WE    = d_WE;
                m_DAT_M = d_DAT_M;
                d_ACK   = m_ACK;
            end
            default: ;
        endcase
    end

    assign i_DAT_S = m_DAT_S;
    assign d_DAT_S = m_DAT_S;
    assign grant   = state_q;

endmodule

// File: tb/tb_wishbone_arbiter.sv
module tb_wishbone_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  i_ADR, d_ADR, m_ADR;
    logic [15:0]  i_SEL, d_SEL, m_SEL;
    logic         i_STB, i_CYC, i_WE, i_ACK;
    logic         d_STB, d_CYC, d_WE, d_ACK;
    logic         m_STB, m_CYC, m_WE, m_ACK;
    logic [127:0] i_DAT_M, i_DAT_S, d_DAT_M, d_DAT_S, m_DAT_M, m_DAT_S;
    logic [1:0]   grant;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0]  adr;
        logic [15:0]  sel;
        logic         we;
        logic [127:0] datm;
        logic [127:0] dats;
    } item_t;

    item_t      exp_i[$];
    item_t      exp_d[$];
    logic [1:0] exp_gnt[$];

    bit mem_en = 1'b0;

    wishbone_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_ADR(i_ADR), .i_SEL(i_SEL), .i_STB(i_STB), .i_CYC(i_CYC), .i_WE(i_WE),
        .i_DAT_M(i_DAT_M), .i_DAT_S(i_DAT_S), .i_ACK(i_ACK),
        .d_ADR(d_ADR), .d_SEL(d_SEL), .d_STB(d_STB), .d_CYC(d_CYC), .d_WE(d_WE),
        .d_DAT_M(d_DAT_M), .d_DAT_S(d_DAT_S), .d_ACK(d_ACK),
        .m_ADR(m_ADR), .m_SEL(m_SEL), .m_STB(m_STB), .m_CYC(m_CYC), .m_WE(m_WE),
        .m_DAT_M(m_DAT_M), .m_DAT_S(m_DAT_S), .m_ACK(m_ACK),
        .grant(grant)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mem_data(input logic [11:0] a);
        return {8{4'hC, a}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory model: ACK on the third cycle of a live request, one cycle wide.
    initial begin
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                if (m_ACK) begin
                    m_ACK = 1'b0;
                    n = 0;
                end else if (m_CYC && m_STB) begin
                    n++;
                    if (n == 3) begin
                        m_ACK   = 1'b1;
                        m_DAT_S = mem_data(m_ADR);
                    end
                end else begin
                    n = 0;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        item_t      it;
        logic [1:0] g;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (grant == 2'b00) begin
                    chk("idle_mem_outputs",
                        {m_CYC, m_STB, m_WE, m_ADR, m_SEL, (m_DAT_M != 128'd0)}, '0);
                end
                if (i_ACK && d_ACK) chk("both_ack", 1, 0);
                if (i_ACK || d_ACK) begin
                    if (exp_gnt.size() == 0) begin
                        chk("unexpected_ack", {i_ACK, d_ACK}, 2'b00);
                    end else begin
                        g = exp_gnt.pop_front();
                        chk("grant_order", grant, g);
                    end
                    chk("dat_s_broadcast", i_DAT_S, d_DAT_S);
                end
                if (i_ACK) begin
                    if (exp_i.size() == 0) chk("unexpected_i_ack", i_ACK, 0);
                    else begin
                        it = exp_i.pop_front();
                        chk("i_adr",  m_ADR,   it.adr);
                        chk("i_sel",  m_SEL,   it.sel);
                        chk("i_we",   m_WE,    it.we);
                        chk("i_datm", m_DAT_M, it.datm);
                        chk("i_dats", i_DAT_S, it.dats);
                        chk("i_other_ack", d_ACK, 0);
                    end
                end
                if (d_ACK) begin
                    if (exp_d.size() == 0) chk("unexpected_d_ack", d_ACK, 0);
                    else begin
                        it = exp_d.pop_front();
                        chk("d_adr",  m_ADR,   it.adr);
                        chk("d_sel",  m_SEL,   it.sel);
                        chk("d_we",   m_WE,    it.we);
                        chk("d_datm", m_DAT_M, it.datm);
                        chk("d_dats", d_DAT_S, it.dats);
                        chk("d_other_ack", i_ACK, 0);
                    end
                end
            end
        end
    end

    task automatic i_xfer(input logic [11:0] adr, input bit hold);
        item_t it;
        bit    got;
        it.adr = adr; it.sel = 16'hFFFF; it.we = 1'b0; it.datm = '0; it.dats = mem_data(adr);
        exp_i.push_back(it);
        i_ADR = adr; i_SEL = 16'hFFFF; i_WE = 1'b0; i_DAT_M = '0;
        i_CYC = 1'b1; i_STB = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = i_ACK;
        end
        if (!got) chk("i_ack_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) begin i_CYC = 1'b0; i_STB = 1'b0; end
    endtask

    task automatic d_xfer(input logic [11:0] adr, input logic [15:0] sel, input logic we,
                          input logic [127:0] dat, input bit hold);
        item_t it;
        bit    got;
        it.adr = adr; it.sel = sel; it.we = we; it.datm = dat; it.dats = mem_data(adr);
        exp_d.push_back(it);
        d_ADR = adr; d_SEL = sel; d_WE = we; d_DAT_M = dat;
        d_CYC = 1'b1; d_STB = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = d_ACK;
        end
        if (!got) chk("d_ack_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) begin d_CYC = 1'b0; d_STB = 1'b0; end
    endtask

    task automatic wait_grant(input logic [1:0] g, input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = (grant == g);
        end
        if (!seen) chk(name, grant, g);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        i_ADR = '0; i_SEL = '0; i_STB = 0; i_CYC = 0; i_WE = 0; i_DAT_M = '0;
        d_ADR = '0; d_SEL = '0; d_STB = 0; d_CYC = 0; d_WE = 0; d_DAT_M = '0;
        m_ACK = 1'b0; m_DAT_S = '0;
        #23;
        chk("rst_grant", grant, 2'b00);
        chk("rst_mcyc",  {m_CYC, m_STB, m_WE}, 3'b000);
        chk("rst_acks",  {i_ACK, d_ACK}, 2'b00);
        chk("rst_madr",  m_ADR, 12'h000);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_en = 1'b1;
        @(posedge clk); #1;

        // Single ifetch
        exp_gnt.push_back(2'b01);
        fork
            i_xfer(12'h0A3, 0);
            begin
                @(posedge clk); #1;
                chk("single_i_grant", grant, 2'b01);
                chk("single_i_madr",  m_ADR, 12'h0A3);
                chk("single_i_mwe",   m_WE, 1'b0);
            end
        join
        @(posedge clk); #1;
        chk("single_i_back_idle", grant, 2'b00);

        // Simultaneous: data first, ifetch after one IDLE cycle
        exp_gnt.push_back(2'b10);
        exp_gnt.push_back(2'b01);
        fork
            d_xfer(12'h010, 16'hFFFF, 1'b0, '0, 0);
            i_xfer(12'h020, 0);
        join
        @(posedge clk); #1;

        // Starvation, run twice: the second round only matches if the counter cleared
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) exp_gnt.push_back(2'b10);
            exp_gnt.push_back(2'b01);
            exp_gnt.push_back(2'b10);
            fork
                begin
                    for (int k = 0; k < 5; k++)
                        d_xfer(12'h100 + 12'(r * 16 + k), 16'hFFFF, 1'b0, '0, k < 4);
                end
                i_xfer(12'h200 + 12'(r), 0);
            join
            @(posedge clk); #1;
        end

        // Data write
        exp_gnt.push_back(2'b10);
        d_xfer(12'h345, 16'h0003, 1'b1, 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF, 0);
        @(posedge clk); #1;

        // Abort in second GNT_D cycle
        mem_en = 1'b0;
        d_ADR = 12'h077; d_SEL = 16'hFFFF; d_WE = 0; d_DAT_M = '0;
        d_CYC = 1'b1; d_STB = 1'b1;
        wait_grant(2'b10, "abort_grant_timeout");
        @(posedge clk); #1;
        chk("abort_still_gnt_d", grant, 2'b10);
        d_CYC = 1'b0;
        #1;
        chk("abort_mcyc_low", m_CYC, 1'b0);
        @(posedge clk); #1;
        chk("abort_back_idle", grant, 2'b00);
        d_STB = 1'b0;
        @(posedge clk); #1;

        // Reset mid GNT_I
        i_ADR = 12'h0C1; i_SEL = 16'hFFFF; i_WE = 0; i_DAT_M = '0;
        i_CYC = 1'b1; i_STB = 1'b1;
        wait_grant(2'b01, "rstmid_grant_timeout");
        #2;
        chk("rstmid_mcyc_before", m_CYC, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstmid_grant", grant, 2'b00);
        chk("rstmid_mcyc",  m_CYC, 1'b0);
        m_ACK = 1'b1;
        #1;
        chk("rstmid_no_ack", i_ACK, 1'b0);
        i_CYC = 1'b0; i_STB = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("late_ack_grant", grant, 2'b00);
        chk("late_ack_not_fwd", {i_ACK, d_ACK}, 2'b00);
        m_ACK = 1'b0;
        @(posedge clk); #1;

        chk("scoreboard_i_empty", exp_i.size(), 0);
        chk("scoreboard_d_empty", exp_d.size(), 0);
        chk("scoreboard_g_empty", exp_gnt.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
